// File: rtl/skinny_tk_pkg.sv
// Shared constants, cell helpers and FSM encoding for the SKINNY tweakey schedulers.
package skinny_tk_pkg;

    localparam int CELL_W          = 8;
    localparam int N_CELLS         = 16;
    localparam int ROUNDS_128_384  = 56;
    localparam int ROUNDS_PLUS     = 40;

    // PT^-1 as a gather table: out cell i takes in cell PT_INV_IDX[i].
    // The forward PT is the matching scatter: out cell PT_INV_IDX[i] takes in cell i.
    localparam logic [15:0][3:0] PT_INV_IDX = {
        4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
        4'd13, 4'd15, 4'd11, 4'd8, 4'd9, 4'd12, 4'd10, 4'd14
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // (x7..x0) -> (x6..x0, x7^x5)
    function automatic logic [7:0] lfsr2_fwd(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5]};
    endfunction

    // (x7..x0) -> (x0^x6, x7..x1)
    function automatic logic [7:0] lfsr3_fwd(input logic [7:0] x);
        return {x[0] ^ x[6], x[7:1]};
    endfunction

    // Undoes lfsr2_fwd: y -> (y0^y6, y7..y1)
    function automatic logic [7:0] lfsr2_inv(input logic [7:0] y);
        return {y[0] ^ y[6], y[7:1]};
    endfunction

    // Undoes lfsr3_fwd: y -> (y6..y0, y7^y5)
    function automatic logic [7:0] lfsr3_inv(input logic [7:0] y);
        return {y[6:0], y[7] ^ y[5]};
    endfunction

endpackage

// File: rtl/skinny_tweak_perm.sv
// Forward tweakey cell permutation PT (combinational, 16 x 8-bit cells).
module skinny_tweak_perm
    import skinny_tk_pkg::*;
(
    input  logic [127:0] tk_in,
    output logic [127:0] tk_out
);

    // Scatter each input cell to the position PT^-1 would read it from.
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        assign tk_out[CELL_W*PT_INV_IDX[gi] +: CELL_W] = tk_in[CELL_W*gi +: CELL_W];
    end

endmodule

// File: rtl/skinny_tweak_perm_inv.sv
// Inverse tweakey cell permutation PT^-1 (combinational, 16 x 8-bit cells).
module skinny_tweak_perm_inv
    import skinny_tk_pkg::*;
(
    input  logic [127:0] tk_in,
    output logic [127:0] tk_out
);

    // Gather: out cell gi comes from in cell PT_INV_IDX[gi].
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        assign tk_out[CELL_W*gi +: CELL_W] = tk_in[CELL_W*PT_INV_IDX[gi] +: CELL_W];
    end

endmodule

// File: rtl/skinny_tweakey_inv_sched.sv
// Decryption-side SKINNY-128-384 tweakey scheduler: unwinds forward to the last
// round, then streams round tweakeys from round ROUNDS-1 down to round 0.
module skinny_tweakey_inv_sched
    import skinny_tk_pkg::*;
#(
    parameter int ROUNDS = 56,
    parameter int RW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic          load_final,
    input  logic [127:0]  tk1_in,
    input  logic [127:0]  tk2_in,
    input  logic [127:0]  tk3_in,
    output logic          rtk_valid,
    input  logic          rtk_ready,
    output logic [63:0]   rtk_out,
    output logic [RW-1:0] rtk_round,
    output logic          rtk_last,
    output logic          busy
);

    state_t        state_reg, state_next;
    logic [RW-1:0] cnt_reg, cnt_next;
    logic [127:0]  tk1_reg, tk2_reg, tk3_reg;
    logic [127:0]  tk1_next, tk2_next, tk3_next;

    logic [127:0]  tk1_fp, tk2_fp, tk3_fp;     // after forward PT
    logic [127:0]  tk2_fwd, tk3_fwd;           // after forward LFSRs
    logic [127:0]  tk2_il, tk3_il;             // after inverse LFSRs
    logic [127:0]  tk1_inv, tk2_inv, tk3_inv;  // after PT^-1

    skinny_tweak_perm u_fp1 (.tk_in(tk1_reg), .tk_out(tk1_fp));
    skinny_tweak_perm u_fp2 (.tk_in(tk2_reg), .tk_out(tk2_fp));
    skinny_tweak_perm u_fp3 (.tk_in(tk3_reg), .tk_out(tk3_fp));

    // LFSRs only touch the upper half (rows 0-1); forward applies them after PT,
    // inverse applies them before PT^-1.
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_lfsr
        if (gi >= 8) begin : g_upper
            assign tk2_fwd[CELL_W*gi +: CELL_W] = lfsr2_fwd(tk2_fp[CELL_W*gi +: CELL_W]);
            assign tk3_fwd[CELL_W*gi +: CELL_W] = lfsr3_fwd(tk3_fp[CELL_W*gi +: CELL_W]);
            assign tk2_il[CELL_W*gi +: CELL_W]  = lfsr2_inv(tk2_reg[CELL_W*gi +: CELL_W]);
            assign tk3_il[CELL_W*gi +: CELL_W]  = lfsr3_inv(tk3_reg[CELL_W*gi +: CELL_W]);
        end else begin : g_lower
            assign tk2_fwd[CELL_W*gi +: CELL_W] = tk2_fp[CELL_W*gi +: CELL_W];
            assign tk3_fwd[CELL_W*gi +: CELL_W] = tk3_fp[CELL_W*gi +: CELL_W];
            assign tk2_il[CELL_W*gi +: CELL_W]  = tk2_reg[CELL_W*gi +: CELL_W];
            assign tk3_il[CELL_W*gi +: CELL_W]  = tk3_reg[CELL_W*gi +: CELL_W];
        end
    end

    skinny_tweak_perm_inv u_ip1 (.tk_in(tk1_reg), .tk_out(tk1_inv));
    skinny_tweak_perm_inv u_ip2 (.tk_in(tk2_il),  .tk_out(tk2_inv));
    skinny_tweak_perm_inv u_ip3 (.tk_in(tk3_il),  .tk_out(tk3_inv));

    // State, round counter and tweakey registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tk1_reg   <= '0;
            tk2_reg   <= '0;
            tk3_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tk1_reg   <= tk1_next;
            tk2_reg   <= tk2_next;
            tk3_reg   <= tk3_next;
        end
    end

    // Next-state logic: load in IDLE, forward steps in FWD, inverse step per accepted beat in EMIT.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tk1_next   = tk1_reg;
        tk2_next   = tk2_reg;
        tk3_next   = tk3_reg;
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    tk1_next = tk1_in;
                    tk2_next = tk2_in;
                    tk3_next = tk3_in;
                    if (load_final) begin
                        state_next = EMIT;
                        cnt_next   = RW'(ROUNDS - 1);
                    end else begin
                        state_next = FWD;
                        cnt_next   = '0;
                    end
                end
            end
            FWD: begin
                tk1_next = tk1_fp;
                tk2_next = tk2_fwd;
                tk3_next = tk3_fwd;
                cnt_next = cnt_reg + RW'(1);
                if (cnt_reg == RW'(ROUNDS - 2)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (rtk_ready) begin
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        tk1_next = tk1_inv;
                        tk2_next = tk2_inv;
                        tk3_next = tk3_inv;
                        cnt_next = cnt_reg - RW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign load_ready = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign rtk_valid  = (state_reg == EMIT);
    assign rtk_round  = cnt_reg;
    assign rtk_last   = (state_reg == EMIT) && (cnt_reg == '0);
    assign rtk_out    = (state_reg == EMIT) ? (tk1_reg[127:64] ^ tk2_reg[127:64] ^ tk3_reg[127:64]) : '0;

endmodule

// File: tb/tb_skinny_tweakey_inv_sched.sv
// Directed bench for the inverse tweakey scheduler (ROUNDS = 56, 3 and 2 instances).
module tb_skinny_tweakey_inv_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_final;
    logic [127:0] tk1_in, tk2_in, tk3_in;
    logic         rtk_ready;

    logic lv56, lr56, rv56, rl56, busy56;
    logic [63:0] ro56;
    logic [5:0]  rr56;
    logic lv3, lr3, rv3, rl3, busy3;
    logic [63:0] ro3;
    logic [1:0]  rr3;
    logic lv2, lr2, rv2, rl2, busy2;
    logic [63:0] ro2;
    logic [0:0]  rr2;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_rtk [0:55];

    localparam logic [127:0] M1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] M2 = 128'hA5A5F00D12345678_9ABCDEF0C3C3E1E1;
    localparam logic [127:0] M3 = 128'h1F2E3D4C5B6A7988_97A6B5C4D3E2F100;

    always #5 clk = ~clk;

    skinny_tweakey_inv_sched #(.ROUNDS(56), .RW(6)) dut56 (
        .clk(clk), .rst(rst), .load_valid(lv56), .load_ready(lr56), .load_final(load_final),
        .tk1_in(tk1_in), .tk2_in(tk2_in), .tk3_in(tk3_in), .rtk_valid(rv56), .rtk_ready(rtk_ready),
        .rtk_out(ro56), .rtk_round(rr56), .rtk_last(rl56), .busy(busy56));

    skinny_tweakey_inv_sched #(.ROUNDS(3), .RW(2)) dut3 (
        .clk(clk), .rst(rst), .load_valid(lv3), .load_ready(lr3), .load_final(load_final),
        .tk1_in(tk1_in), .tk2_in(tk2_in), .tk3_in(tk3_in), .rtk_valid(rv3), .rtk_ready(rtk_ready),
        .rtk_out(ro3), .rtk_round(rr3), .rtk_last(rl3), .busy(busy3));

    skinny_tweakey_inv_sched #(.ROUNDS(2), .RW(1)) dut2 (
        .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2), .load_final(load_final),
        .tk1_in(tk1_in), .tk2_in(tk2_in), .tk3_in(tk3_in), .rtk_valid(rv2), .rtk_ready(rtk_ready),
        .rtk_out(ro2), .rtk_round(rr2), .rtk_last(rl2), .busy(busy2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Forward PT written as a scatter from the PT^-1 table.
    function automatic logic [127:0] fperm(input logic [127:0] x);
        logic [127:0] o;
        int inv_t [16] = '{14, 10, 12, 9, 8, 11, 15, 13, 0, 1, 2, 3, 4, 5, 6, 7};
        o = '0;
        for (int j = 0; j < 16; j++) o[8*inv_t[j] +: 8] = x[8*j +: 8];
        return o;
    endfunction

    // Golden forward schedule: round r tweakey stored in exp_rtk[r].
    task automatic build_model(input logic [127:0] a, input logic [127:0] b, input logic [127:0] c);
        logic [7:0] x;
        for (int r = 0; r < 56; r++) begin
            exp_rtk[r] = a[127:64] ^ b[127:64] ^ c[127:64];
            a = fperm(a);
            b = fperm(b);
            c = fperm(c);
            for (int cc = 8; cc < 16; cc++) begin
                x = b[8*cc +: 8];
                b[8*cc +: 8] = {x[6:0], x[7] ^ x[5]};
                x = c[8*cc +: 8];
                c[8*cc +: 8] = {x[0] ^ x[6], x[7:1]};
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (lr56 !== 1'b1) begin failures++; $display("FAIL reset_load_ready: got %b expected 1", lr56); end
        checks++; if (rv56 !== 1'b0) begin failures++; $display("FAIL reset_rtk_valid: got %b expected 0", rv56); end
        checks++; if (ro56 !== 64'h0) begin failures++; $display("FAIL reset_rtk_out: got %h expected 0", ro56); end
        checks++; if (rr56 !== 6'd0) begin failures++; $display("FAIL reset_rtk_round: got %0d expected 0", rr56); end
        checks++; if (rl56 !== 1'b0 || busy56 !== 1'b0) begin failures++; $display("FAIL reset_last_busy: got %b%b expected 00", rl56, busy56); end
        $display("reset: load_ready=%b rtk_valid=%b busy=%b", lr56, rv56, busy56);
    endtask

    task automatic test_final_two_rounds;
        tk1_in = 128'h0F0E0D0C0B0A0908_0706050403020100;
        tk2_in = '0; tk3_in = '0;
        load_final = 1'b1; rtk_ready = 1'b1;
        lv2 = 1'b1;
        tick();
        lv2 = 1'b0;
        checks++; if (rv2 !== 1'b1 || ro2 !== 64'h0F0E0D0C0B0A0908 || rr2 !== 1'b1 || rl2 !== 1'b0)
            begin failures++; $display("FAIL r2_beat1: got v=%b out=%h rnd=%0d last=%b expected v=1 out=0f0e0d0c0b0a0908 rnd=1 last=0", rv2, ro2, rr2, rl2); end
        $display("r2 beat1: out=%h round=%0d last=%b", ro2, rr2, rl2);
        tick();
        checks++; if (rv2 !== 1'b1 || ro2 !== 64'h0706050403020100 || rr2 !== 1'b0 || rl2 !== 1'b1)
            begin failures++; $display("FAIL r2_beat2: got v=%b out=%h rnd=%0d last=%b expected v=1 out=0706050403020100 rnd=0 last=1", rv2, ro2, rr2, rl2); end
        $display("r2 beat2: out=%h round=%0d last=%b", ro2, rr2, rl2);
        tick();
        checks++; if (rv2 !== 1'b0 || lr2 !== 1'b1 || busy2 !== 1'b0)
            begin failures++; $display("FAIL r2_idle: got v=%b ready=%b busy=%b expected 0 1 0", rv2, lr2, busy2); end
    endtask

    task automatic test_lfsr_inverse;
        tk1_in = '0;
        tk2_in = 128'h00000000_00000001_00000000_00000000;
        tk3_in = 128'h00000000_00000001_00000000_00000000;
        load_final = 1'b1; rtk_ready = 1'b1;
        lv3 = 1'b1;
        tick();
        lv3 = 1'b0;
        checks++; if (rv3 !== 1'b1 || ro3 !== 64'h0 || rr3 !== 2'd2)
            begin failures++; $display("FAIL lfsr_beat1: got v=%b out=%h rnd=%0d expected v=1 out=0 rnd=2", rv3, ro3, rr3); end
        tick();
        // Both bytes were moved to cell 4 (lower half) by the first inverse step.
        checks++; if (rv3 !== 1'b1 || ro3 !== 64'h0 || rr3 !== 2'd1)
            begin failures++; $display("FAIL lfsr_beat2: got v=%b out=%h rnd=%0d expected v=1 out=0 rnd=1", rv3, ro3, rr3); end
        tick();
        // Cell 4 moves to cell 12: TK2 0x80 xor TK3 0x02.
        checks++; if (rv3 !== 1'b1 || ro3 !== 64'h00000082_00000000 || rr3 !== 2'd0 || rl3 !== 1'b1)
            begin failures++; $display("FAIL lfsr_beat3: got v=%b out=%h rnd=%0d last=%b expected v=1 out=0000008200000000 rnd=0 last=1", rv3, ro3, rr3, rl3); end
        $display("lfsr beat3: out=%h round=%0d", ro3, rr3);
        tick();
        checks++; if (rv3 !== 1'b0 || lr3 !== 1'b1)
            begin failures++; $display("FAIL lfsr_idle: got v=%b ready=%b expected 0 1", rv3, lr3); end
    endtask

    task automatic test_back_to_back;
        int lat;
        tk1_in = M1; tk2_in = M2; tk3_in = M3;
        load_final = 1'b0; rtk_ready = 1'b1;
        lv56 = 1'b1;
        tick();
        lv56 = 1'b0;
        lat = 1;
        while (rv56 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        checks++; if (lat != 56) begin failures++; $display("FAIL b2b_latency: got %0d expected 56", lat); end
        for (int k = 55; k >= 0; k--) begin
            checks++;
            if (rv56 !== 1'b1 || ro56 !== exp_rtk[k] || rr56 !== 6'(k) || rl56 !== (k == 0))
                begin failures++; $display("FAIL b2b_beat%0d: got v=%b out=%h rnd=%0d last=%b expected out=%h", k, rv56, ro56, rr56, rl56, exp_rtk[k]); end
            if (k == 0) begin
                checks++;
                if (ro56 !== (M1[127:64] ^ M2[127:64] ^ M3[127:64]))
                    begin failures++; $display("FAIL b2b_round0_master: got %h expected %h", ro56, M1[127:64] ^ M2[127:64] ^ M3[127:64]); end
            end
            $display("b2b beat round=%0d out=%h", rr56, ro56);
            tick();
        end
        checks++; if (rv56 !== 1'b0 || lr56 !== 1'b1)
            begin failures++; $display("FAIL b2b_idle: got v=%b ready=%b expected 0 1", rv56, lr56); end
    endtask

    task automatic test_backpressure;
        int lat;
        int k;
        int guard;
        logic rdy;
        tk1_in = M1; tk2_in = M2; tk3_in = M3;
        load_final = 1'b0; rtk_ready = 1'b0;
        lv56 = 1'b1;
        tick();
        lv56 = 1'b0;
        lat = 1;
        while (rv56 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        checks++; if (lat != 56) begin failures++; $display("FAIL bp_latency: got %0d expected 56", lat); end
        k = 55;
        guard = 0;
        while (k >= 0 && guard < 1000) begin
            checks++;
            if (rv56 !== 1'b1 || ro56 !== exp_rtk[k] || rr56 !== 6'(k))
                begin failures++; $display("FAIL bp_beat%0d: got v=%b out=%h rnd=%0d expected out=%h", k, rv56, ro56, rr56, exp_rtk[k]); end
            rdy = 1'($urandom_range(0, 1));
            rtk_ready = rdy;
            $display("bp cycle: round=%0d out=%h ready=%b", rr56, ro56, rdy);
            tick();
            if (rdy) k--;
            guard++;
        end
        checks++; if (k >= 0) begin failures++; $display("FAIL bp_timeout: got %0d beats left expected 0", k + 1); end
        checks++; if (rv56 !== 1'b0 || lr56 !== 1'b1)
            begin failures++; $display("FAIL bp_idle: got v=%b ready=%b expected 0 1", rv56, lr56); end
        rtk_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run;
        int lat;
        tk1_in = M1; tk2_in = M2; tk3_in = M3;
        load_final = 1'b0; rtk_ready = 1'b1;
        lv56 = 1'b1;
        tick();
        lv56 = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rv56 !== 1'b0 || lr56 !== 1'b1 || busy56 !== 1'b0)
            begin failures++; $display("FAIL rst_fwd: got v=%b ready=%b busy=%b expected 0 1 0", rv56, lr56, busy56); end
        $display("reset in FWD: load_ready=%b busy=%b", lr56, busy56);
        lv56 = 1'b1;
        tick();
        lv56 = 1'b0;
        lat = 1;
        while (rv56 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        for (int k = 55; k >= 53; k--) begin
            checks++;
            if (rv56 !== 1'b1 || ro56 !== exp_rtk[k] || rr56 !== 6'(k))
                begin failures++; $display("FAIL rst_pre_beat%0d: got v=%b out=%h rnd=%0d expected out=%h", k, rv56, ro56, rr56, exp_rtk[k]); end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rv56 !== 1'b0 || lr56 !== 1'b1 || ro56 !== 64'h0 || rr56 !== 6'd0)
            begin failures++; $display("FAIL rst_emit: got v=%b ready=%b out=%h rnd=%0d expected 0 1 0 0", rv56, lr56, ro56, rr56); end
        $display("reset in EMIT: load_ready=%b rtk_valid=%b", lr56, rv56);
        repeat (3) begin
            tick();
            checks++; if (rv56 !== 1'b0) begin failures++; $display("FAIL rst_no_beat: got v=%b expected 0", rv56); end
        end
        lv56 = 1'b1;
        tick();
        lv56 = 1'b0;
        lat = 1;
        while (rv56 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        checks++; if (lat != 56) begin failures++; $display("FAIL rst_reload_latency: got %0d expected 56", lat); end
        for (int k = 55; k >= 0; k--) begin
            checks++;
            if (rv56 !== 1'b1 || ro56 !== exp_rtk[k] || rr56 !== 6'(k))
                begin failures++; $display("FAIL rst_reload_beat%0d: got v=%b out=%h rnd=%0d expected out=%h", k, rv56, ro56, rr56, exp_rtk[k]); end
            tick();
        end
        $display("reload after reset: sequence of 56 beats compared");
    endtask

    task automatic test_load_ignored;
        int lat;
        tk1_in = M1; tk2_in = M2; tk3_in = M3;
        load_final = 1'b0; rtk_ready = 1'b1;
        lv56 = 1'b1;
        tick();
        lv56 = 1'b0;
        tk1_in = ~M1; tk2_in = ~M2; tk3_in = ~M3;
        lat = 1;
        while (rv56 !== 1'b1 && lat < 200) begin
            if (lat == 5) begin
                lv56 = 1'b1;
                load_final = 1'b1;
            end else begin
                lv56 = 1'b0;
            end
            tick();
            lat++;
        end
        lv56 = 1'b0;
        checks++; if (lat != 56) begin failures++; $display("FAIL ign_latency: got %0d expected 56", lat); end
        for (int k = 55; k >= 0; k--) begin
            checks++;
            if (rv56 !== 1'b1 || ro56 !== exp_rtk[k] || rr56 !== 6'(k))
                begin failures++; $display("FAIL ign_beat%0d: got v=%b out=%h rnd=%0d expected out=%h", k, rv56, ro56, rr56, exp_rtk[k]); end
            lv56 = (k == 45);
            $display("ignore-load beat round=%0d out=%h", rr56, ro56);
            tick();
        end
        lv56 = 1'b0;
        checks++; if (rv56 !== 1'b0 || lr56 !== 1'b1)
            begin failures++; $display("FAIL ign_idle: got v=%b ready=%b expected 0 1", rv56, lr56); end
    endtask

    initial begin
        rst = 1'b1;
        load_final = 1'b0;
        tk1_in = '0; tk2_in = '0; tk3_in = '0;
        rtk_ready = 1'b0;
        lv56 = 1'b0; lv3 = 1'b0; lv2 = 1'b0;
        build_model(M1, M2, M3);
        test_reset();
        test_final_two_rounds();
        test_lfsr_inverse();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_load_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
